// File: rtl/img_pkg.sv
// Shared types and geometry for the image line feeder.
// Imported by the feeder top and its credit counter.
package img_pkg;

  localparam int IMG_LINE_W      = 512;
  localparam int IMG_NUM_LINES   = 512;
  localparam int IMG_NUM_LINEBUF = 4;
  localparam int IMG_DW          = 8;

  typedef logic [IMG_DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_CREDIT,
    ST_DONE
  } feed_state_e;

endpackage

// File: rtl/line_credit_ctr.sv
// Saturating line-credit counter with sticky overflow flag.
// Simultaneous inc and dec cancel out.
module line_credit_ctr
  import img_pkg::*;
#(
  parameter int MAX = IMG_NUM_LINEBUF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] credits,
  output logic       zero,
  output logic       err
);

  localparam logic [2:0] CMAX = 3'(MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      credits <= '0;
      err     <= 1'b0;
    end else if (load) begin
      credits <= CMAX;
    end else if (inc && !dec) begin
      if (credits == CMAX)
        err <= 1'b1;
      else
        credits <= credits + 3'd1;
    end else if (dec && !inc) begin
      credits <= credits - 3'd1;
    end
  end

  assign zero = (credits == 3'd0);

endmodule

// File: rtl/img_line_feeder.sv
// Line-credit flow-controlled pixel feeder into the
// line-buffer window controller.
module img_line_feeder
  import img_pkg::*;
#(
  parameter int LINE_W        = IMG_LINE_W,
  parameter int NUM_LINES     = IMG_NUM_LINES,
  parameter int PRELOAD_LINES = IMG_NUM_LINEBUF,
  parameter int DW            = IMG_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] o_pixel,
  output logic          o_pixel_valid,
  input  logic          i_interrupt,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic [9:0]    o_lines_sent,
  output logic          o_credit_err
);

  localparam int PW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(LINE_W - 1);
  localparam logic [9:0] LINE_LAST = 10'(NUM_LINES - 1);

  feed_state_e   state;
  feed_state_e   state_n;
  logic [PW-1:0] pix_cnt;
  logic [2:0]    credits;
  logic          cr_zero;
  logic          beat;
  logic          line_end;
  logic          start_ok;
  logic          cr_inc;

  assign s_ready  = (state == ST_SEND);
  assign beat     = s_valid && s_ready;
  assign line_end = beat && (pix_cnt == PIX_LAST);
  assign start_ok = i_start && (state == ST_IDLE);
  assign cr_inc   = i_interrupt &&
                    ((state == ST_SEND) ||
                     (state == ST_WAIT_CREDIT));

  assign o_frame_done = (state == ST_DONE);

  line_credit_ctr #(
    .MAX (PRELOAD_LINES)
  ) u_cred (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load    (start_ok),
    .inc     (cr_inc),
    .dec     (line_end),
    .credits (credits),
    .zero    (cr_zero),
    .err     (o_credit_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Last credit spent without a coincident refill stalls the stream.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_n = ST_SEND;
      end
      ST_SEND: begin
        if (line_end) begin
          if (o_lines_sent == LINE_LAST)
            state_n = ST_DONE;
          else if (credits == 3'd1 && !cr_inc)
            state_n = ST_WAIT_CREDIT;
        end else if (cr_zero) begin
          state_n = ST_WAIT_CREDIT;
        end
      end
      ST_WAIT_CREDIT: begin
        if (i_interrupt) state_n = ST_SEND;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_cnt       <= '0;
      o_lines_sent  <= '0;
      o_busy        <= 1'b0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_pixel_valid <= beat;
      if (beat)
        o_pixel <= s_data;
      if (start_ok) begin
        pix_cnt      <= '0;
        o_lines_sent <= '0;
        o_busy       <= 1'b1;
      end else begin
        if (beat)
          pix_cnt <= line_end ? '0 : pix_cnt + PW'(1);
        if (line_end)
          o_lines_sent <= o_lines_sent + 10'd1;
        if (state == ST_DONE)
          o_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_img_line_feeder.sv
// Randomized scoreboard bench for img_line_feeder on a
// reduced frame geometry.
module tb_img_line_feeder;

  localparam int LW = 16;
  localparam int NL = 12;
  localparam int PL = 4;
  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] o_pixel;
  logic          o_pixel_valid;
  logic          i_interrupt = 1'b0;
  logic          o_busy;
  logic          o_frame_done;
  logic [9:0]    o_lines_sent;
  logic          o_credit_err;

  always #5 i_clk = ~i_clk;

  img_line_feeder #(
    .LINE_W        (LW),
    .NUM_LINES     (NL),
    .PRELOAD_LINES (PL),
    .DW            (DW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .o_pixel       (o_pixel),
    .o_pixel_valid (o_pixel_valid),
    .i_interrupt   (i_interrupt),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_lines_sent  (o_lines_sent),
    .o_credit_err  (o_credit_err)
  );

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [DW-1:0] exp_q[$];

  int credits_m = 0;
  int lines_m = 0;
  int pix_m = 0;
  int total_m = 0;
  int frame_beats = 0;
  int stalls = 0;
  bit active_m = 0;
  bit busy_m = 0;
  bit err_m = 0;
  bit done_pend = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  always @(negedge i_clk)
    if (s_valid && s_ready && !i_rst)
      exp_q.push_back(s_data);

  always @(negedge i_clk) begin
    if (o_pixel_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected actual=%0d expected=none",
                 o_pixel);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("pixel", int'(o_pixel), int'(e));
      end
    end
  end

  always @(negedge i_clk)
    if (o_frame_done === 1'b1) fd_cnt++;

  task automatic step(bit v, bit intr, bit st, bit r);
    bit beat, comp, int_eff, idle_before;
    s_valid     = v;
    s_data      = DW'($urandom);
    i_interrupt = intr;
    i_start     = st;
    i_rst       = r;
    @(negedge i_clk);
    if (!r) begin
      chk("s_ready", int'(s_ready),
          int'(active_m && credits_m > 0));
      if (active_m && !s_ready) stalls++;
    end
    beat = v && (s_ready === 1'b1) && !r;
    @(posedge i_clk);
    #1;
    if (r) begin
      active_m = 0; busy_m = 0; err_m = 0;
      done_pend = 0; credits_m = 0;
      lines_m = 0; pix_m = 0;
      exp_q.delete();
      return;
    end
    idle_before = !busy_m;
    if (done_pend) begin
      busy_m = 0;
      done_pend = 0;
    end
    comp = beat && (pix_m == LW - 1);
    int_eff = intr && active_m;
    if (beat) begin
      pix_m = comp ? 0 : pix_m + 1;
      total_m++;
      frame_beats++;
    end
    if (comp) lines_m++;
    if (comp && int_eff) begin
    end else if (comp) begin
      credits_m--;
    end else if (int_eff) begin
      if (credits_m == PL) err_m = 1;
      else credits_m++;
    end
    if (comp && lines_m == NL) begin
      active_m = 0;
      done_pend = 1;
    end
    if (st && idle_before) begin
      active_m = 1; busy_m = 1;
      credits_m = PL; lines_m = 0;
      pix_m = 0; frame_beats = 0;
    end
    chk("lines_sent", int'(o_lines_sent), lines_m);
    chk("credit_err", int'(o_credit_err), int'(err_m));
    chk("busy", int'(o_busy), int'(busy_m));
  endtask

  task automatic reset_checks();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_pixel", int'(o_pixel), 0);
    chk("rst_pixel_valid", int'(o_pixel_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_frame_done", int'(o_frame_done), 0);
    chk("rst_lines_sent", int'(o_lines_sent), 0);
    chk("rst_credit_err", int'(o_credit_err), 0);
    chk("rst_credits", int'(dut.u_cred.credits), 0);
  endtask

  task automatic run_frame(int limit);
    int n;
    n = 0;
    while (busy_m && n < limit) begin
      step(bit'($urandom_range(0, 1)),
           credits_m < PL && $urandom_range(0, 7) == 0,
           0, 0);
      n++;
    end
    chk("frame_in_budget", int'(busy_m), 0);
  endtask

  initial begin
    int base, n;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    reset_checks();

    step(0, 0, 1, 0);
    repeat (100) step(1, 0, 0, 0);
    chk("preload_beats", total_m, PL * LW);
    chk("preload_lines", int'(o_lines_sent), PL);
    chk("preload_stall", int'(s_ready), 0);

    step(0, 0, 1, 0);
    base = total_m;
    step(0, 1, 0, 0);
    repeat (40) step(1, 0, 0, 0);
    chk("one_credit_beats", total_m - base, LW);
    chk("one_credit_lines", int'(o_lines_sent), PL + 1);
    chk("one_credit_stall", int'(s_ready), 0);

    step(0, 1, 0, 0);
    stalls = 0;
    n = 0;
    while (lines_m < 7 && n < 200) begin
      step(1, (lines_m == 5 && (pix_m == 3 || pix_m == 5)) ||
              (lines_m == 6 && pix_m == LW - 1), 0, 0);
      n++;
    end
    chk("coincident_credits", int'(dut.u_cred.credits), 2);
    chk("coincident_no_stall", stalls, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("full_credits", int'(dut.u_cred.credits), PL);
    step(0, 1, 0, 0);
    chk("overflow_err", int'(o_credit_err), 1);
    chk("overflow_credits", int'(dut.u_cred.credits), PL);

    run_frame(3000);
    step(0, 0, 0, 0);
    chk("frame1_done_pulses", fd_cnt, 1);
    chk("frame1_beats", frame_beats, NL * LW);
    chk("frame1_busy", int'(o_busy), 0);

    step(0, 0, 1, 0);
    n = 0;
    while (!(lines_m == 2 && pix_m == 5) && n < 1000) begin
      step(bit'($urandom_range(0, 1)), 0, 0, 0);
      n++;
    end
    chk("reached_line3", lines_m * LW + pix_m, 2 * LW + 5);
    step(0, 0, 0, 1);
    reset_checks();
    repeat (3) step(0, 1, 0, 0);
    chk("idle_irq_no_err", int'(o_credit_err), 0);

    step(0, 0, 1, 0);
    chk("restart_credits", int'(dut.u_cred.credits), PL);
    chk("restart_pix", int'(dut.pix_cnt), 0);
    run_frame(3000);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("frame2_done_pulses", fd_cnt, 2);
    chk("frame2_beats", frame_beats, NL * LW);
    chk("frame2_lines", int'(o_lines_sent), NL);
    chk("frame2_busy", int'(o_busy), 0);
    chk("frame2_err", int'(o_credit_err), 0);
    repeat (3) step(0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_line_feeder.md
Name: img_line_feeder

Overview:
Transmit-side companion of the line-buffer window controller. Accepts raw 8-bit pixels from an upstream stream source (DMA/AXI-Stream style valid/ready) and forwards them as a valid-only pixel stream into the line-buffer controller. Uses line-credit flow control so the 4-entry line-buffer ring can never be overwritten:
- preloads PRELOAD_LINES lines;
- then releases one further line per consumer interrupt (one interrupt = one line read out).

Parameters:
LINE_W, 512, pixels per image line
NUM_LINES, 512, lines per frame
PRELOAD_LINES, 4, initial line credits (= number of line buffers in the consumer)
DW, 8, pixel width in bits

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_start  in  1  one-cycle pulse; starts a frame when idle
s_data  in  DW  upstream pixel
s_valid  in  1  upstream pixel valid
s_ready  out  1  upstream ready (combinational from registered state)
o_pixel  out  DW  pixel to consumer, registered
o_pixel_valid  out  1  one-cycle qualifier for o_pixel
i_interrupt  in  1  consumer line-read-done pulse; returns one credit
o_busy  out  1  high from accepted start until frame done
o_frame_done  out  1  one-cycle pulse after last pixel of last line is sent
o_lines_sent  out  10  lines fully sent in current frame
o_credit_err  out  1  sticky: interrupt received while credits already at PRELOAD_LINES

Behaviour:
- Reset values: s_ready=0, o_pixel=0, o_pixel_valid=0, o_busy=0, o_frame_done=0, o_lines_sent=0, o_credit_err=0. FSM=IDLE, credits=0, pix_cnt=0.
- Reset mid-frame aborts immediately. No pulses are generated.

FSM states: IDLE, SEND, WAIT_CREDIT, DONE.
- IDLE:
  - On i_start: credits<=PRELOAD_LINES, pix_cnt<=0, o_lines_sent<=0, o_busy<=1, go to SEND.
  - i_interrupt is ignored in IDLE.
- SEND:
  - s_ready=1.
  - Each beat (s_valid&s_ready) registers s_data into o_pixel and sets o_pixel_valid=1 next cycle (latency 1). Otherwise o_pixel_valid=0 and o_pixel holds.
  - pix_cnt increments per beat. On a beat with pix_cnt==LINE_W-1: pix_cnt<=0, o_lines_sent+1, credits-1.
  - After the last line completes: go to DONE.
  - Else, if resulting credits==0: go to WAIT_CREDIT.
  - Else: stay in SEND.
- WAIT_CREDIT:
  - s_ready=0.
  - On i_interrupt: credits becomes 1, go to SEND.
- DONE:
  - s_ready=0.
  - o_frame_done=1 for one cycle, o_busy<=0, go to IDLE.
- s_ready is 0 in every state except SEND.

Credit rules:
- credits is 3 bits and saturates at PRELOAD_LINES.
- i_interrupt in SEND/WAIT_CREDIT adds 1.
- Interrupt in the same cycle as line completion: credits unchanged.
- Interrupt with credits==PRELOAD_LINES and no simultaneous line completion: credits unchanged, o_credit_err<=1.
- Interrupts after DONE or in IDLE are ignored and never set the error.

Other rules:
- i_start while o_busy is ignored.
- Upstream stalls (s_valid=0) mid-line are legal: counters hold and o_pixel_valid=0.
- o_lines_sent is LINE_W/NUM_LINES-width-agnostic: 10 bits covers NUM_LINES up to 1023. Larger NUM_LINES is out of scope.

Decomposition:
- Shared package img_pkg holds:
  - FSM state enum;
  - IMG_LINE_W=512, IMG_NUM_LINES=512, IMG_NUM_LINEBUF=4;
  - pixel typedef (DW bits).
- Sub-module line_credit_ctr, small and natural: holds the saturating credit counter and error flag. Inputs are load/inc/dec; outputs are credits, zero, err.
- The FSM and pixel counter stay in img_line_feeder.

Test Plan:
- Reset then i_start with s_valid held 1 → exactly 2048 beats accepted with o_pixel_valid one cycle after each beat; s_ready drops the cycle after pixel 2047; o_lines_sent=4; no further beats.
- From that stall, pulse i_interrupt once → exactly 512 more pixels, o_lines_sent=5, s_ready=0 again.
- Full frame with an interrupt issued 600 cycles after each line start → 262144 pixels total, o_frame_done pulses once after the last beat, o_busy falls, o_credit_err=0.
- i_interrupt coincident with the beat completing line 2 (credits 2) → credits stays 2 and streaming continues without a stall; extra interrupt at credits=4 → o_credit_err=1 and credits=4.
- Random s_valid gaps (50% duty) → o_pixel sequence equals the input sequence in order; the pixel counter does not advance on gaps.
- Assert i_rst mid-line 3 → all outputs at reset values next cycle; a subsequent i_start sends from pixel 0 with 4 fresh credits.
